// File: rtl/hps_rst_seq_pkg.sv
// Shared types and helpers for the HPS reset sequencer.
//   seq_state_t : sequencer FSM states
//   rst_type_t  : which reset request a sequence is driving
//   req_n_of()  : active-low request vector {cold, warm, dbg} for a type
//   pick_type() : fixed-priority arbitration, cold > warm > dbg
package hps_rst_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    WAIT_ACK,
    WAIT_REL,
    HOLDOFF
  } seq_state_t;

  typedef enum logic [1:0] {
    NONE,
    COLD,
    WARM,
    DBG
  } rst_type_t;

  // Request vector ordering is {cold, warm, dbg}; all released = 3'b111.
  localparam logic [2:0] REQ_ALL_OFF = 3'b111;

  // One-cold encoding guarantees at most one request line is low.
  function automatic logic [2:0] req_n_of(rst_type_t t);
    logic [2:0] r;
    r = REQ_ALL_OFF;
    case (t)
      COLD:    r = 3'b011;
      WARM:    r = 3'b101;
      DBG:     r = 3'b110;
      default: r = REQ_ALL_OFF;
    endcase
    return r;
  endfunction

  function automatic rst_type_t pick_type(logic cold, logic warm, logic dbg);
    rst_type_t t;
    t = NONE;
    if (cold)      t = COLD;
    else if (warm) t = WARM;
    else if (dbg)  t = DBG;
    return t;
  endfunction

endpackage

// File: rtl/hps_rst_sync2.sv
// Two-flop synchronizer for the HPS reset status line.
// Resets to 1 so a freshly reset sequencer sees "HPS out of reset" until
// the real level has propagated through both stages.
//   clk, rst : system clock, async active-high reset
//   d        : asynchronous input
//   q        : synchronized output (2 clk latency)
module hps_rst_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hps_reset_sequencer.sv
// HPS reset sequencer.
// Turns single-cycle cold/warm/debug reset pulses into held, active-low
// fabric-to-HPS reset requests, tracks the HPS handshake on h2f_rst_n and
// enforces a guard interval before the next sequence may start.
//
// Build option: define HPS_RST_SEQ_TIMEOUT_EN to bound the handshake wait
// by ACK_TIMEOUT cycles and report expiry on the sticky timeout_err.
// Without it the handshake states wait forever and timeout_err is 0.
//
// Ports:
//   clk, rst            : system clock, async active-high reset
//   cold/warm/dbg_pulse : one-cycle reset request pulses
//   h2f_rst_n           : HPS reset status (async, low while HPS in reset)
//   f2h_*_rst_req_n     : registered active-low request lines
//   busy                : high whenever a sequence is in progress
//   timeout_err         : sticky handshake timeout flag
module hps_reset_sequencer
  import hps_rst_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned ACK_TIMEOUT    = 1024,
  parameter int unsigned HOLDOFF_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cold_pulse,
  input  logic warm_pulse,
  input  logic dbg_pulse,
  input  logic h2f_rst_n,
  output logic f2h_cold_rst_req_n,
  output logic f2h_warm_rst_req_n,
  output logic f2h_dbg_rst_req_n,
  output logic busy,
  output logic timeout_err
);

  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ACK_LD     = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLDOFF_LD = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  logic             hps_rst_s;
  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             pend_cold, pend_warm, pend_dbg;
  logic [2:0]       req_n;
  logic             busy_q;

  // In IDLE a pulse arriving this cycle is served immediately, so the
  // arbiter looks at flags OR'd with the live pulses.
  logic      any_cold, any_warm, any_dbg;
  rst_type_t nxt_type;

  assign any_cold = pend_cold | cold_pulse;
  assign any_warm = pend_warm | warm_pulse;
  assign any_dbg  = pend_dbg  | dbg_pulse;
  assign nxt_type = pick_type(any_cold, any_warm, any_dbg);

  hps_rst_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (h2f_rst_n),
    .q   (hps_rst_s)
  );

`ifdef HPS_RST_SEQ_TIMEOUT_EN
  logic timeout_q;
  // The shared counter hits zero on the edge where it holds 1.
  logic ack_expired;
  assign ack_expired = (cnt == CNT_ONE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= CNT_ZERO;
      pend_cold <= 1'b0;
      pend_warm <= 1'b0;
      pend_dbg  <= 1'b0;
      req_n     <= REQ_ALL_OFF;
      busy_q    <= 1'b0;
`ifdef HPS_RST_SEQ_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      // Pulses are never dropped: they accumulate in every state and are
      // only cleared when a sequence of the matching type starts.
      pend_cold <= any_cold;
      pend_warm <= any_warm;
      pend_dbg  <= any_dbg;

      case (state)
        IDLE: begin
          if (nxt_type != NONE) begin
            state  <= ASSERT;
            cnt    <= HOLD_LD;
            req_n  <= req_n_of(nxt_type);
            busy_q <= 1'b1;
            case (nxt_type)
              // A cold reset subsumes warm and debug requests.
              COLD: begin
                pend_cold <= 1'b0;
                pend_warm <= 1'b0;
                pend_dbg  <= 1'b0;
              end
              WARM:    pend_warm <= 1'b0;
              DBG:     pend_dbg  <= 1'b0;
              default: ;
            endcase
          end
        end

        ASSERT: begin
          if (cnt == CNT_ONE) begin
            state <= WAIT_ACK;
            cnt   <= ACK_LD;
            req_n <= REQ_ALL_OFF;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // The timeout budget spans both handshake states and is not
        // reloaded on the WAIT_ACK -> WAIT_REL step; expiry wins over a
        // simultaneous handshake edge.
        WAIT_ACK: begin
`ifdef HPS_RST_SEQ_TIMEOUT_EN
          if (ack_expired) begin
            timeout_q <= 1'b1;
            state     <= HOLDOFF;
            cnt       <= HOLDOFF_LD;
          end else begin
            cnt <= cnt - 1'b1;
            if (!hps_rst_s) state <= WAIT_REL;
          end
`else
          if (!hps_rst_s) state <= WAIT_REL;
`endif
        end

        WAIT_REL: begin
`ifdef HPS_RST_SEQ_TIMEOUT_EN
          if (ack_expired) begin
            timeout_q <= 1'b1;
            state     <= HOLDOFF;
            cnt       <= HOLDOFF_LD;
          end else if (hps_rst_s) begin
            state <= HOLDOFF;
            cnt   <= HOLDOFF_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
`else
          if (hps_rst_s) begin
            state <= HOLDOFF;
            cnt   <= HOLDOFF_LD;
          end
`endif
        end

        // Counts HOLDOFF_CYCLES down to 0 inclusive, so a zero guard still
        // spends one cycle here.
        HOLDOFF: begin
          if (cnt == CNT_ZERO) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          req_n  <= REQ_ALL_OFF;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign f2h_cold_rst_req_n = req_n[2];
  assign f2h_warm_rst_req_n = req_n[1];
  assign f2h_dbg_rst_req_n  = req_n[0];
  assign busy               = busy_q;

`ifdef HPS_RST_SEQ_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
